// File: rtl/anita3_readout_pkg.sv
// Shared types and widths for the ANITA-3 readout sequencer.
package anita3_readout_pkg;

    localparam int unsigned BUF_W = 2;
    localparam int unsigned SRC_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDigStart,
        StDigWait,
        StRead,
        StClear
    } state_e;

    typedef struct packed {
        logic [BUF_W-1:0] buffer;
        logic [SRC_W-1:0] source;
    } req_t;

endpackage

// File: rtl/anita3_req_fifo.sv
// Request FIFO: synchronous, first-word fall-through head, occupancy count.
// DEPTH must be a power of 2 and at least 2.
module anita3_req_fifo
    import anita3_readout_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk250_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  req_t                     wdata,
    input  logic                     pop,
    output req_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk250_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/anita3_readout_sequencer.sv
// Digitize/readout/clear sequencer fed by a request FIFO.
// Optional digitizer timeout is enabled by defining ANITA3_READOUT_TIMEOUT_EN.
module anita3_readout_sequencer
    import anita3_readout_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DIG_TIMEOUT = 4096
) (
    input  logic                          clk250_i,
    input  logic                          rst_i,
    input  logic                          digitize_i,
    input  logic [BUF_W-1:0]              digitize_buffer_i,
    input  logic [SRC_W-1:0]              digitize_source_i,
    output logic                          dig_start_o,
    output logic [BUF_W-1:0]              dig_buffer_o,
    input  logic                          dig_done_i,
    output logic                          readout_valid_o,
    output logic [BUF_W-1:0]              readout_buffer_o,
    output logic [SRC_W-1:0]              readout_source_o,
    input  logic                          readout_ack_i,
    output logic                          clear_o,
    output logic [BUF_W-1:0]              clear_buffer_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic                          timeout_o
);

    state_e state_q, state_d;
    req_t   work_q, fifo_head;
    logic   dq, push, pop, fifo_full, fifo_empty, tmo_hit;
    logic   dig_start_q, readout_valid_q, clear_q, busy_q, overflow_q;

    assign push = digitize_i & ~dq;

    anita3_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk250_i (clk250_i),
        .rst_i    (rst_i),
        .push     (push),
        .wdata    ({digitize_buffer_i, digitize_source_i}),
        .pop      (pop),
        .rdata    (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending_o)
    );

`ifdef ANITA3_READOUT_TIMEOUT_EN
    logic [15:0] tmr_q;
    logic        timeout_q;

    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q <= (state_q == StDigWait) ? tmr_q + 1'b1 : '0;
            if (tmo_hit && !dig_done_i) timeout_q <= 1'b1;
        end
    end

    assign tmo_hit   = (state_q == StDigWait) && (tmr_q == 16'(DIG_TIMEOUT - 1));
    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StDigStart;
                end
            end
            StDigStart: state_d = StDigWait;
            StDigWait: begin
                if (dig_done_i)   state_d = StRead;
                else if (tmo_hit) state_d = StClear;
            end
            StRead:  if (readout_ack_i) state_d = StClear;
            StClear: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            dq              <= 1'b0;
            work_q          <= '0;
            dig_start_q     <= 1'b0;
            readout_valid_q <= 1'b0;
            clear_q         <= 1'b0;
            busy_q          <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            dq              <= digitize_i;
            if (pop) work_q <= fifo_head;
            dig_start_q     <= (state_d == StDigStart);
            readout_valid_q <= (state_d == StRead);
            clear_q         <= (state_d == StClear);
            busy_q          <= (state_d != StIdle);
            if (push && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign dig_start_o      = dig_start_q;
    assign dig_buffer_o     = work_q.buffer;
    assign readout_valid_o  = readout_valid_q;
    assign readout_buffer_o = work_q.buffer;
    assign readout_source_o = work_q.source;
    assign clear_o          = clear_q;
    assign clear_buffer_o   = work_q.buffer;
    assign busy_o           = busy_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_anita3_readout_sequencer.sv
// Directed self-checking bench for anita3_readout_sequencer.
module tb_anita3_readout_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digitize = 1'b0;
    logic [1:0] dbuf = '0;
    logic [3:0] dsrc = '0;
    logic       dig_done = 1'b0;
    logic       ack = 1'b0;
    logic       dig_start_o, readout_valid_o, clear_o, busy_o, overflow_o, timeout_o;
    logic [1:0] dig_buffer_o, readout_buffer_o, clear_buffer_o;
    logic [3:0] readout_source_o;
    logic [2:0] pending_o;

    int checks = 0;
    int errors = 0;
    int n_clear = 0, n_start = 0, n_valid = 0;
    int base_clear, base_start, base_valid;

    always #2 clk = ~clk;

    anita3_readout_sequencer #(
        .FIFO_DEPTH  (4),
        .DIG_TIMEOUT (16)
    ) dut (
        .clk250_i          (clk),
        .rst_i             (rst),
        .digitize_i        (digitize),
        .digitize_buffer_i (dbuf),
        .digitize_source_i (dsrc),
        .dig_start_o       (dig_start_o),
        .dig_buffer_o      (dig_buffer_o),
        .dig_done_i        (dig_done),
        .readout_valid_o   (readout_valid_o),
        .readout_buffer_o  (readout_buffer_o),
        .readout_source_o  (readout_source_o),
        .readout_ack_i     (ack),
        .clear_o           (clear_o),
        .clear_buffer_o    (clear_buffer_o),
        .pending_o         (pending_o),
        .busy_o            (busy_o),
        .overflow_o        (overflow_o),
        .timeout_o         (timeout_o)
    );

    // Pulse counters sample the value held during the cycle that just ended.
    always @(posedge clk) begin
        if (clear_o)         n_clear++;
        if (dig_start_o)     n_start++;
        if (readout_valid_o) n_valid++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, dig_start_o, dig_buffer_o, readout_valid_o, readout_buffer_o,
                readout_source_o, clear_o, clear_buffer_o, pending_o, busy_o,
                overflow_o, timeout_o};
    endfunction

    task automatic push_req(input logic [1:0] b, input logic [3:0] s);
        digitize = 1'b1; dbuf = b; dsrc = s;
        tick();
        digitize = 1'b0;
        tick();
    endtask

    task automatic service(input bit need_start, input logic [1:0] b, input logic [3:0] s);
        if (need_start) begin
            int k = 0;
            while (!dig_start_o && k < 50) begin tick(); k++; end
            chk("dig_start_seen", dig_start_o, 1);
            chk("dig_buffer", dig_buffer_o, b);
            tick();
        end
        chk("wait_busy", busy_o, 1);
        chk("wait_dig_buffer", dig_buffer_o, b);
        dig_done = 1'b1; tick(); dig_done = 1'b0;
        chk("readout_valid", readout_valid_o, 1);
        chk("readout_buffer", readout_buffer_o, b);
        chk("readout_source", readout_source_o, s);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("clear_pulse", clear_o, 1);
        chk("clear_buffer", clear_buffer_o, b);
        tick();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single request, buffer 2, source 5
        base_clear = n_clear;
        digitize = 1'b1; dbuf = 2'd2; dsrc = 4'b0101;
        tick();
        chk("t1_pending_push", pending_o, 1);
        chk("t1_no_start_yet", dig_start_o, 0);
        digitize = 1'b0;
        tick();
        chk("t1_dig_start", dig_start_o, 1);
        chk("t1_dig_buffer", dig_buffer_o, 2);
        chk("t1_pending_pop", pending_o, 0);
        tick();
        chk("t1_start_one_cycle", dig_start_o, 0);
        repeat (8) tick();
        chk("t1_no_valid_early", readout_valid_o, 0);
        dig_done = 1'b1; tick(); dig_done = 1'b0;
        chk("t1_valid", readout_valid_o, 1);
        chk("t1_rbuf", readout_buffer_o, 2);
        chk("t1_rsrc", readout_source_o, 5);
        repeat (2) tick();
        chk("t1_valid_held", readout_valid_o, 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t1_clear", clear_o, 1);
        chk("t1_clear_buf", clear_buffer_o, 2);
        chk("t1_valid_drop", readout_valid_o, 0);
        tick();
        chk("t1_clear_one_cycle", clear_o, 0);
        chk("t1_idle", busy_o, 0);
        chk("t1_pending_end", pending_o, 0);
        tick();
        chk("t1_clear_count", n_clear - base_clear, 1);

        // 2: four queued requests while the first waits for the digitizer
        base_clear = n_clear;
        for (int i = 0; i < 4; i++) push_req(2'(i), 4'(i + 8));
        chk("t2_pending3", pending_o, 3);
        chk("t2_no_overflow", overflow_o, 0);
        service(1'b0, 2'd0, 4'd8);
        for (int i = 1; i < 4; i++) service(1'b1, 2'(i), 4'(i + 8));
        tick();
        chk("t2_clear_count", n_clear - base_clear, 4);
        chk("t2_pending_end", pending_o, 0);

        // 3: overflow; one held in work regs + 4 queued, the 6th is dropped
        base_clear = n_clear;
        for (int i = 0; i < 5; i++) push_req(2'(i), 4'(i + 1));
        chk("t3_pending_full", pending_o, 4);
        chk("t3_no_overflow_yet", overflow_o, 0);
        push_req(2'd1, 4'd6);
        chk("t3_overflow", overflow_o, 1);
        chk("t3_pending_unchanged", pending_o, 4);
        service(1'b0, 2'd0, 4'd1);
        for (int i = 1; i < 5; i++) service(1'b1, 2'(i), 4'(i + 1));
        repeat (4) tick();
        chk("t3_clear_count", n_clear - base_clear, 5);
        chk("t3_idle", busy_o, 0);
        chk("t3_overflow_sticky", overflow_o, 1);

        // 4: level held 25 cycles is one request
        base_clear = n_clear;
        base_start = n_start;
        digitize = 1'b1; dbuf = 2'd3; dsrc = 4'd9;
        tick();
        chk("t4_pending1", pending_o, 1);
        repeat (24) tick();
        digitize = 1'b0;
        tick();
        chk("t4_one_start", n_start - base_start, 1);
        chk("t4_pending0", pending_o, 0);
        service(1'b0, 2'd3, 4'd9);
        repeat (3) tick();
        chk("t4_clear_count", n_clear - base_clear, 1);
        chk("t4_idle", busy_o, 0);

        // 5: reset while readout_valid is high
        push_req(2'd1, 4'hA);
        tick();
        dig_done = 1'b1; tick(); dig_done = 1'b0;
        chk("t5_in_read", readout_valid_o, 1);
        base_clear = n_clear;
        rst = 1'b1;
        #1;
        chk("t5_async_reset", all_outs(), 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t5_no_clear", n_clear - base_clear, 0);
        chk("t5_pending0", pending_o, 0);
        chk("t5_idle", busy_o, 0);

`ifdef ANITA3_READOUT_TIMEOUT_EN
        // 6: digitizer never finishes; timeout frees the buffer without readout
        begin
            int k = 0;
            base_valid = n_valid;
            push_req(2'd2, 4'h3);
            while (!clear_o && k < 100) begin tick(); k++; end
            chk("t6_clear_seen", clear_o, 1);
            chk("t6_clear_buf", clear_buffer_o, 2);
            chk("t6_timeout", timeout_o, 1);
            tick();
            chk("t6_no_valid", n_valid - base_valid, 0);
            repeat (3) tick();
            chk("t6_timeout_sticky", timeout_o, 1);
        end
`else
        chk("timeout_tied_low", timeout_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
